// File: rtl/bldc_commutation_gen.sv
// Six-step open-loop BLDC commutation and PWM gate pattern generator with dead-time.
// Optional PATGEN_DIR_EN adds the dir port for reverse rotation; forward-only otherwise.
module bldc_commutation_gen #(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned STEP_PERIODS = 16,
    parameter int unsigned DEAD_TICKS   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_in,
    input  logic                en,
`ifdef PATGEN_DIR_EN
    input  logic                dir,
`endif
    input  logic [PWM_BITS-1:0] duty,
    output logic [2:0]          gate_hi,
    output logic [2:0]          gate_lo,
    output logic [2:0]          step,
    output logic                pwm_wrap
);

    localparam int unsigned PER_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(STEP_PERIODS - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    logic                tick_d;
    logic [1:0]          state_q, state_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic [2:0]          step_q, step_d;
    logic [2:0]          gate_hi_q, gate_hi_d;
    logic [2:0]          gate_lo_q, gate_lo_d;
    logic                pwm_wrap_q, pwm_wrap_d;

    logic       tick;
    logic       wrap;
    logic       comm;
    logic       step_rev;
    logic [2:0] step_fwd;
    logic [2:0] step_bwd;
    logic [2:0] hi_sel;
    logic [2:0] lo_sel;
    logic       pwm_on;
    logic       gate_on;

    assign tick = tick_in & ~tick_d;
    assign wrap = (state_q != ST_IDLE) & tick & (pwm_cnt_q == {PWM_BITS{1'b1}});
    assign comm = wrap & (per_cnt_q == PER_LAST);

`ifdef PATGEN_DIR_EN
    assign step_rev = dir;
`else
    assign step_rev = 1'b0;
`endif

    assign step_fwd = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
    assign step_bwd = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;

    always_comb begin
        state_d    = state_q;
        pwm_cnt_d  = pwm_cnt_q;
        duty_d     = duty_q;
        per_cnt_d  = per_cnt_q;
        dead_cnt_d = dead_cnt_q;
        step_d     = step_q;
        pwm_wrap_d = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            pwm_cnt_d  = '0;
            per_cnt_d  = '0;
            dead_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            duty_d  = duty;
        end else begin
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end
            if (wrap) begin
                pwm_wrap_d = 1'b1;
                duty_d     = duty;
                per_cnt_d  = comm ? '0 : per_cnt_q + 1'b1;
            end
            // A commutation event outranks dead-time counting on the same tick.
            if (comm) begin
                step_d     = step_rev ? step_bwd : step_fwd;
                state_d    = ST_DEAD;
                dead_cnt_d = '0;
            end else if ((state_q == ST_DEAD) && tick) begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d    = ST_RUN;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hi_sel = 3'b000;
        lo_sel = 3'b000;
        case (step_q)
            3'd0: begin hi_sel = 3'b001; lo_sel = 3'b010; end
            3'd1: begin hi_sel = 3'b001; lo_sel = 3'b100; end
            3'd2: begin hi_sel = 3'b010; lo_sel = 3'b100; end
            3'd3: begin hi_sel = 3'b010; lo_sel = 3'b001; end
            3'd4: begin hi_sel = 3'b100; lo_sel = 3'b001; end
            3'd5: begin hi_sel = 3'b100; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
        pwm_on = (pwm_cnt_q < duty_q);
        // Gates drop on the same edge that leaves RUN, and rise one edge after entering it.
        gate_on   = (state_q == ST_RUN) && (state_d == ST_RUN);
        gate_hi_d = (gate_on && pwm_on) ? hi_sel : 3'b000;
        gate_lo_d = gate_on ? lo_sel : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d     <= 1'b0;
            state_q    <= ST_IDLE;
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            per_cnt_q  <= '0;
            dead_cnt_q <= '0;
            step_q     <= 3'd0;
            gate_hi_q  <= 3'b000;
            gate_lo_q  <= 3'b000;
            pwm_wrap_q <= 1'b0;
        end else begin
            tick_d     <= tick_in;
            state_q    <= state_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            per_cnt_q  <= per_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            step_q     <= step_d;
            gate_hi_q  <= gate_hi_d;
            gate_lo_q  <= gate_lo_d;
            pwm_wrap_q <= pwm_wrap_d;
        end
    end

    assign gate_hi  = gate_hi_q;
    assign gate_lo  = gate_lo_q;
    assign step     = step_q;
    assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_bldc_commutation_gen.sv
// Bench for bldc_commutation_gen: random tick spacing and duty changes against a tick-count model.
module tb_bldc_commutation_gen;

    localparam int PWM_BITS     = 8;
    localparam int STEP_PERIODS = 2;
    localparam int DEAD_TICKS   = 2;
    localparam int PERIOD       = 1 << PWM_BITS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                tick_in;
    logic                en;
    logic [PWM_BITS-1:0] duty;
    logic [2:0]          gate_hi;
    logic [2:0]          gate_lo;
    logic [2:0]          step;
    logic                pwm_wrap;
`ifdef PATGEN_DIR_EN
    logic                dir;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int t;
    int t_ev;
    int m_step;
    int m_duty;
    int hi_cnt;
    logic prev_wrap = 1'b0;

    // Phase index driven high / low in each step: A=0, B=1, C=2.
    int hi_ph [6] = '{0, 0, 1, 1, 2, 2};
    int lo_ph [6] = '{1, 2, 2, 0, 0, 1};

    always #5 clk = ~clk;

    bldc_commutation_gen #(
        .PWM_BITS    (PWM_BITS),
        .STEP_PERIODS(STEP_PERIODS),
        .DEAD_TICKS  (DEAD_TICKS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .en      (en),
`ifdef PATGEN_DIR_EN
        .dir     (dir),
`endif
        .duty    (duty),
        .gate_hi (gate_hi),
        .gate_lo (gate_lo),
        .step    (step),
        .pwm_wrap(pwm_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cur_dir();
`ifdef PATGEN_DIR_EN
        return int'(dir);
`else
        return 0;
`endif
    endfunction

    task automatic check_pins(input string tag);
        logic [2:0] eh;
        logic [2:0] el;
        eh = 3'b000;
        el = 3'b000;
        if (t - t_ev >= DEAD_TICKS) begin
            el[lo_ph[m_step]] = 1'b1;
            eh[hi_ph[m_step]] = ((t % PERIOD) < m_duty);
        end
        chk({tag, "_hi"}, gate_hi, eh);
        chk({tag, "_lo"}, gate_lo, el);
        chk({tag, "_step"}, step, m_step);
    endtask

    // Called at posedge+1 with tick_in low; gates follow 2 clk after en rises.
    task automatic enter_run();
        en = 1'b1;
        @(posedge clk); #1;
        chk("run_latency_hi", gate_hi, 0);
        chk("run_latency_lo", gate_lo, 0);
        @(posedge clk); #1;
        t      = 0;
        t_ev   = -1000000;
        m_duty = duty;
        check_pins("run_first");
    endtask

    task automatic do_tick(input int hold, input int gap);
        bit is_wrap;
        bit is_ev;
        tick_in = 1'b1;
        @(posedge clk); #1;
        if (hold == 1) tick_in = 1'b0;
        t++;
        is_wrap = (t % PERIOD == 0);
        is_ev   = is_wrap && ((t / PERIOD) % STEP_PERIODS == 0);
        if (is_wrap) m_duty = duty;
        if (is_ev) begin
            m_step = (cur_dir() != 0) ? (m_step + 5) % 6 : (m_step + 1) % 6;
            t_ev   = t;
        end
        chk("wrap_pulse", pwm_wrap, is_wrap);
        if (is_ev) begin
            chk("comm_edge_hi", gate_hi, 0);
            chk("comm_edge_lo", gate_lo, 0);
            chk("comm_edge_step", step, m_step);
        end
        @(posedge clk); #1;
        if (hold <= 2) tick_in = 1'b0;
        chk("wrap_after", pwm_wrap, 0);
        check_pins("tick");
        for (int k = 2; k < hold; k++) begin
            @(posedge clk); #1;
        end
        tick_in = 1'b0;
        for (int k = 0; k < gap; k++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        chk("hi_lo_overlap", gate_hi & gate_lo, 0);
        chk("wrap_width", pwm_wrap & prev_wrap, 0);
        prev_wrap = pwm_wrap;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        en      = 1'b0;
        tick_in = 1'b0;
        duty    = '0;
`ifdef PATGEN_DIR_EN
        dir     = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", gate_hi, 0);
        chk("reset_lo", gate_lo, 0);
        chk("reset_step", step, 0);
        chk("reset_wrap", pwm_wrap, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Long run: full rotation and more, with mid-period duty changes.
        m_step = 0;
        duty   = 8'd64;
        enter_run();
        hi_cnt = int'(gate_hi[0]);
        for (int i = 1; i < PERIOD * STEP_PERIODS * 7 + 40; i++) begin
            if (i == 300) duty = 8'd0;
            else if (i == 600) duty = 8'd255;
            else if (i > 1000 && $urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: duty = 8'd0;
                    1: duty = 8'd255;
                    2: duty = 8'd64;
                    default: duty = 8'($urandom_range(0, 255));
                endcase
            end
`ifdef PATGEN_DIR_EN
            if ($urandom_range(0, 99) == 0) dir = ~dir;
`endif
            do_tick($urandom_range(1, 3), $urandom_range(1, 2));
            if (t < PERIOD) hi_cnt += int'(gate_hi[0]);
        end
        chk("duty64_on_ticks", hi_cnt, 64);

        // Drop en mid-RUN: gates off at the next edge, step holds.
        en = 1'b0;
        @(posedge clk); #1;
        chk("en_off_hi", gate_hi, 0);
        chk("en_off_lo", gate_lo, 0);
        chk("en_off_step", step, m_step);
        @(posedge clk); #1;
        chk("idle_hi", gate_hi, 0);
        chk("idle_lo", gate_lo, 0);

        // Restart, run into DEAD, then reset asynchronously mid-cycle.
        duty = 8'd100;
        enter_run();
        for (int i = 0; i < PERIOD * STEP_PERIODS; i++) begin
            do_tick(1, 1);
        end
        chk("pre_reset_step", step, m_step);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_rst_step", step, 0);
        chk("async_rst_hi", gate_hi, 0);
        chk("async_rst_lo", gate_lo, 0);
        chk("async_rst_wrap", pwm_wrap, 0);
        m_step = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        duty = 8'd200;
        enter_run();
        for (int i = 0; i < PERIOD + 10; i++) begin
            do_tick($urandom_range(1, 3), $urandom_range(1, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bldc_commutation_gen.md
# bldc_commutation_gen

- Six-step open-loop commutation and PWM pattern generator for the BLDC bridge.
- Consumes the 5 MHz divided clock level produced by the pattern-generator clock divider and treats each of its rising edges as one timebase tick.
- Produces registered high-side/low-side gate enables for phases A/B/C, with dead-time inserted at every commutation step.
- Sits between the clock divider and the gate-driver output pins.

## Interface
- PWM_BITS, 8, width of PWM counter and duty input; PWM period = 2^PWM_BITS ticks
- STEP_PERIODS, 16, PWM periods per commutation step (≥1)
- DEAD_TICKS, 2, ticks with all gates off after each step change (≥1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick_in  in  1  divided clock level (same clk domain); rising edge = one tick
- en  in  1  run enable
- dir  in  1  rotation direction, 0 = forward, 1 = reverse (present only with PATGEN_DIR_EN)
- duty  in  PWM_BITS  high-side on-time in ticks per PWM period
- gate_hi  out  3  high-side enables, bit0 = A, bit1 = B, bit2 = C
- gate_lo  out  3  low-side enables, same bit order
- step  out  3  current commutation step, 0..5
- pwm_wrap  out  1  one-clk pulse when PWM counter wraps

## Operation
- Edge detect: tick_d <= tick_in; tick = tick_in & ~tick_d. Reset value of tick_d is 0.
- PWM counter: increments on tick and wraps 2^PWM_BITS-1 → 0. pwm_wrap pulses in the clk where the wrap occurs.
- duty_q samples duty at each wrap and at IDLE→RUN. No mid-period duty change.
- pwm_on = (pwm_cnt < duty_q). duty = 0 gives always off; duty = max gives on for max/2^PWM_BITS.
- Period counter increments on each wrap. At STEP_PERIODS-1 plus a wrap, it clears and raises the commutation event.
- Step update:
  - Forward: step = (step+1) mod 6.
  - Reverse: step = (step+5) mod 6.
- Pattern as (hi phase, lo phase) for steps 0..5: (A,B), (A,C), (B,C), (B,A), (C,A), (C,B).
- FSM states: IDLE, RUN, DEAD.
  - IDLE: gates 0; PWM, period and dead counters held at 0; step holds its value. Goes to RUN on en=1.
  - RUN: hi phase bit = pwm_on; lo phase bit = 1; all other bits 0. A commutation event updates step in the same clk and goes to DEAD.
  - DEAD: all gates 0. The PWM and period counters keep running. Goes to RUN after DEAD_TICKS ticks.
  - en=0 in any state: go to IDLE next clk. Gates are 0 from that edge on.
- Invariant: gate_hi[i] & gate_lo[i] is never 1.
- Simultaneous tick, wrap and commutation event: step update wins; DEAD starts and its tick count begins on the next tick.
- Reset mid-operation: all state is cleared immediately (asynchronous).
- Reset values: gate_hi=0, gate_lo=0, step=0, pwm_wrap=0, state=IDLE, all counters 0.

## Timing
- Edge to counter: a tick_in rise sampled at clk edge N updates pwm_cnt at edge N+1.
- Counter to pins: gate outputs reflect the new pwm_cnt at edge N+2 (registered outputs).
- pwm_wrap asserts at the same edge as pwm_cnt → 0, for exactly 1 clk.
- en rise to RUN: 1 clk. The first gate output follows 1 clk later.
- Dead-time: gates go 0 at the edge where step changes. They re-enable at the registered edge after the DEAD_TICKS-th following tick.
- tick_in held high yields a single tick. With the 5 MHz divider, ticks arrive every 10 clk.

## Configuration
- PATGEN_DIR_EN defined: the dir port exists. dir is sampled at each commutation event and selects +1 or -1 step.
- PATGEN_DIR_EN undefined: no dir port. Forward rotation only.

## Test plan
- Reset then en=1, duty=64, PWM_BITS=8 → gate_hi[0] high for 64 of every 256 ticks; gate_lo[1]=1; step=0.
- STEP_PERIODS=2 → step sequence 0,1,2,3,4,5,0 at every 2nd pwm_wrap. All gates 0 for 2 ticks after each change.
- duty=0 and duty=255 → gate_hi stays 0, respectively low for only 1 tick per period. Change duty mid-period → takes effect only after pwm_wrap.
- With PATGEN_DIR_EN, dir=1 from step 0 → steps 5,4,3. Toggle dir during DEAD → applies at the next event only.
- Drop en mid-RUN, then assert rst_n=0 mid-DEAD → gates 0 within 1 clk of en=0 and asynchronously on reset. After reset, step=0.
- Checker on every cycle: no phase has hi and lo both 1; pwm_wrap is 1 clk wide.
